memwb_skid_stage: RTL and testbench

//  Parametrised MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer,

---
 rtl/memwb_skid_stage.sv | 130 +++++++++++++
 tb/tb_memwb_skid_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer (head + skid), flush,
// write-enable decode, WB->EX forwarding lookup and a saturating stall counter.
module memwb_skid_stage #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 22,
  parameter int RD_W      = 5,
  parameter int RF_EN_BIT = 9,
  parameter int HI_EN_BIT = 2,
  parameter int LO_EN_BIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              rf_we,
  output logic              hi_we,
  output logic              lo_we,
  input  logic [RD_W-1:0]   fwd_rs,
  input  logic [RD_W-1:0]   fwd_rt,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is registered and equals "skid slot is empty".
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [RD_W-1:0]   head_rd;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;

  logic accept;
  logic pop;
  logic skid_hit_a, head_hit_a, skid_hit_b, head_hit_b;

  always_comb begin
    accept = in_valid & in_ready;
    pop    = head_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      head_data  <= '0;
      head_rd    <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_rd    <= '0;
      in_ready   <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      if (head_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        head_valid <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (!head_valid) begin
        if (accept) begin
          head_valid <= 1'b1;
          head_ctrl  <= in_ctrl;
          head_data  <= in_data;
          head_rd    <= in_rd;
        end
      end else if (pop) begin
        if (skid_valid) begin
          // in_ready was low this cycle, so no accept can collide with the move
          head_ctrl  <= skid_ctrl;
          head_data  <= skid_data;
          head_rd    <= skid_rd;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end else if (accept) begin
          head_ctrl <= in_ctrl;
          head_data <= in_data;
          head_rd   <= in_rd;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
        skid_rd    <= in_rd;
        in_ready   <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = head_valid;
    out_ctrl  = head_ctrl;
    out_data  = head_data;
    out_rd    = head_rd;
    rf_we     = pop & head_ctrl[RF_EN_BIT] & (head_rd != '0);
    hi_we     = pop & head_ctrl[HI_EN_BIT];
    lo_we     = pop & head_ctrl[LO_EN_BIT];
  end

  // The skid entry is younger than the head, so it wins a double match.
  always_comb begin
    skid_hit_a = skid_valid & skid_ctrl[RF_EN_BIT] & (skid_rd == fwd_rs) & (fwd_rs != '0);
    head_hit_a = head_valid & head_ctrl[RF_EN_BIT] & (head_rd == fwd_rs) & (fwd_rs != '0);
    skid_hit_b = skid_valid & skid_ctrl[RF_EN_BIT] & (skid_rd == fwd_rt) & (fwd_rt != '0);
    head_hit_b = head_valid & head_ctrl[RF_EN_BIT] & (head_rd == fwd_rt) & (fwd_rt != '0);
    fwd_hit_a  = skid_hit_a | head_hit_a;
    fwd_hit_b  = skid_hit_b | head_hit_b;
    fwd_data_a = skid_hit_a ? skid_data : (head_hit_a ? head_data : '0);
    fwd_data_b = skid_hit_b ? skid_data : (head_hit_b ? head_data : '0);
  end

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_memwb_skid_stage;
  localparam int DATA_W = 32, CTRL_W = 22, RD_W = 5, CNT_W = 16;
  localparam logic [CTRL_W-1:0] RF = CTRL_W'(1) << 9;
  localparam logic [CTRL_W-1:0] HI = CTRL_W'(1) << 2;
  localparam logic [CTRL_W-1:0] LO = CTRL_W'(1) << 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data, fwd_data_a, fwd_data_b;
  logic [RD_W-1:0]   in_rd, out_rd, fwd_rs, fwd_rt;
  logic              rf_we, hi_we, lo_we, fwd_hit_a, fwd_hit_b;
  logic [CNT_W-1:0]  stall_cnt;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // reference model state
  entry_t exp_q[$];
  bit     m_ready = 1'b1;
  int     m_cnt = 0;

  memwb_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
    .rf_we(rf_we), .hi_we(hi_we), .lo_we(lo_we),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .stall_cnt(stall_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // model update: a bounded FIFO of depth 2 with a registered "not full" flag
  always @(posedge clk) begin
    bit pop_m, acc_m;
    if (reset) begin
      exp_q.delete();
      m_ready = 1'b1;
      m_cnt = 0;
    end else begin
      pop_m = (exp_q.size() > 0) && out_ready;
      acc_m = in_valid && m_ready;
      if (exp_q.size() > 0 && !out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush) begin
        exp_q.delete();
        m_ready = 1'b1;
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (acc_m) exp_q.push_back('{ctrl: in_ctrl, data: in_data, rd: in_rd});
        m_ready = (exp_q.size() < 2);
      end
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    bit e_hit_a, e_hit_b, e_pop;
    logic [DATA_W-1:0] e_da, e_db;
    entry_t f;
    if (chk_en) begin
      e_pop = (exp_q.size() > 0) && out_ready;
      f = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("m_out_valid", out_valid, exp_q.size() > 0);
      check("m_in_ready", in_ready, m_ready);
      check("m_stall_cnt", stall_cnt, m_cnt);
      if (exp_q.size() > 0) begin
        check("m_out_ctrl", out_ctrl, f.ctrl);
        check("m_out_data", out_data, f.data);
        check("m_out_rd", out_rd, f.rd);
      end
      check("m_rf_we", rf_we, e_pop && f.ctrl[9] && f.rd != 0);
      check("m_hi_we", hi_we, e_pop && f.ctrl[2]);
      check("m_lo_we", lo_we, e_pop && f.ctrl[1]);
      e_hit_a = 0; e_hit_b = 0; e_da = '0; e_db = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
        // later (younger) entries overwrite earlier matches
        if (exp_q[i].ctrl[9] && fwd_rs != 0 && exp_q[i].rd == fwd_rs) begin
          e_hit_a = 1; e_da = exp_q[i].data;
        end
        if (exp_q[i].ctrl[9] && fwd_rt != 0 && exp_q[i].rd == fwd_rt) begin
          e_hit_b = 1; e_db = exp_q[i].data;
        end
      end
      check("m_fwd_hit_a", fwd_hit_a, e_hit_a);
      check("m_fwd_hit_b", fwd_hit_b, e_hit_b);
      check("m_fwd_data_a", fwd_data_a, e_da);
      check("m_fwd_data_b", fwd_data_b, e_db);
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic adv();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic drive(input bit v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
    in_valid = v; in_ctrl = c; in_data = d; in_rd = r;
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0; fwd_rs = 0; fwd_rt = 0;
    drive(0, '0, '0, '0);
    adv(); adv();
    chk_en = 1;
    settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    adv();

    // 1: single entry, latency one cycle
    reset = 0; out_ready = 1;
    drive(1, RF, 32'h1234_5678, 5'd8);
    adv();
    drive(0, '0, '0, '0);
    settle();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 32'h1234_5678);
    check("t1_rf_we", rf_we, 1);
    adv();

    // 2: back-pressure, skid fill, ordered drain
    out_ready = 0;
    drive(1, '0, 32'hA, 5'd1);
    adv();
    drive(1, '0, 32'hB, 5'd2);
    adv();
    drive(0, '0, '0, '0);
    settle();
    check("t2_in_ready_full", in_ready, 0);
    check("t2_head_a", out_data, 32'hA);
    check("t2_stall_1", stall_cnt, 1);
    adv();
    out_ready = 1;
    settle();
    check("t2_stall_2", stall_cnt, 2);
    check("t2_pop_a", out_data, 32'hA);
    adv();
    settle();
    check("t2_pop_b", out_data, 32'hB);
    check("t2_in_ready_back", in_ready, 1);
    adv();
    settle();
    check("t2_empty", out_valid, 0);

    // 3: forwarding, skid wins over head
    out_ready = 0;
    drive(1, RF, 32'h11, 5'd5);
    adv();
    drive(1, RF, 32'h22, 5'd5);
    adv();
    drive(0, '0, '0, '0);
    fwd_rs = 5'd5; fwd_rt = 5'd0;
    settle();
    check("t3_hit_a", fwd_hit_a, 1);
    check("t3_data_a", fwd_data_a, 32'h22);
    check("t3_hit_b", fwd_hit_b, 0);
    check("t3_data_b", fwd_data_b, 0);
    adv();
    fwd_rt = 5'd5; fwd_rs = 5'd6;
    out_ready = 1;
    settle();
    check("t3_hit_rt", fwd_hit_b, 1);
    check("t3_miss_rs", fwd_hit_a, 0);
    adv(); adv();
    fwd_rs = 0; fwd_rt = 0;

    // 4: rd=0 suppresses RF strobe, HI/LO decode
    drive(1, RF | HI, 32'h44, 5'd0);
    adv();
    drive(1, LO, 32'h45, 5'd3);
    settle();
    check("t4_rf_we", rf_we, 0);
    check("t4_hi_we", hi_we, 1);
    check("t4_lo_we", lo_we, 0);
    adv();
    drive(0, '0, '0, '0);
    settle();
    check("t4_lo_we2", lo_we, 1);
    check("t4_hi_we2", hi_we, 0);
    adv();

    // 5: flush with both slots full and an offered entry
    out_ready = 0;
    drive(1, RF, 32'h33, 5'd3);
    adv();
    drive(1, RF, 32'h34, 5'd4);
    adv();
    flush = 1;
    drive(1, RF, 32'h55, 5'd7);
    settle();
    check("t5_no_strobe_stall", rf_we, 0);
    adv();
    flush = 0; out_ready = 1;
    drive(0, '0, '0, '0);
    settle();
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_rf_we", rf_we, 0);
    adv();
    // flush while popping still strobes; offered entry dropped even with in_ready=1
    out_ready = 0;
    drive(1, RF, 32'h66, 5'd6);
    adv();
    flush = 1; out_ready = 1;
    drive(1, RF, 32'h77, 5'd7);
    settle();
    check("t5_pop_in_flush", rf_we, 1);
    adv();
    flush = 0;
    drive(0, '0, '0, '0);
    settle();
    check("t5_dropped", out_valid, 0);
    adv();

    // 6: stall counter saturation, then reset (with flush) mid-stall
    out_ready = 0;
    drive(1, RF, 32'h88, 5'd8);
    adv();
    drive(1, RF, 32'h99, 5'd9);
    adv();
    drive(0, '0, '0, '0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) adv();
    settle();
    check("t6_saturated", stall_cnt, 16'hFFFF);
    adv();
    reset = 1; flush = 1;
    adv();
    reset = 0; flush = 0;
    settle();
    check("t6_rst_cnt", stall_cnt, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_data", out_data, 0);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
